pwm_symbol_scheduler: RTL and testbench

Sequences a WIDTH-bit period counter to produce a pulse-width-modulated output from a stream of duty-cycle symbols. Symbols arrive on a valid/ready handshake. Each symbol is held for a programmable number of counter periods. Symbols are chained back-to-back with no idle cycle, so the block sits between the symbol source (test pattern generator or modulation mapper) and the PWM output pin.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/mod_period_counter.sv | 32 +++
 rtl/pwm_symbol_scheduler.sv | 99 +++++++++
 tb/tb_pwm_symbol_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared FSM state encoding and period-counter constants for the PWM symbol scheduler.
// Pure declarations; no timing or flow control.
package pwm_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Terminal value of a width-bit free-running period counter.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

    // Count value one cycle before the terminal value; used to register tc.
    function automatic int cnt_pre(input int width);
        return cnt_max(width) - 1;
    endfunction

endpackage

// File: rtl/mod_period_counter.sv
// Period counter with a registered terminal-count flag that is high while count==max.
// Latency: tc aligns with count (both registered); clr has priority over en, with no backpressure.
module mod_period_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_PRE = WIDTH'(cnt_pre(WIDTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (en) begin
            count <= count + WIDTH'(1);
            // Flag is computed one cycle early so it is a clean register output.
            tc    <= (count == CNT_PRE);
        end
    end

endmodule

// File: rtl/pwm_symbol_scheduler.sv
// Plays a valid/ready stream of duty symbols as PWM, each for rep+1 periods, back-to-back.
// Latency: first pwm cycle is the clock after transfer; ready only in IDLE or on the last cycle of a symbol.
module pwm_symbol_scheduler
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sym_valid,
    input  logic [WIDTH-1:0] sym_data,
    input  logic [REP_W-1:0] sym_rep,
    output logic             sym_ready,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             busy,
    output logic             underrun
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] duty_reg;
    logic [WIDTH-1:0] duty_nxt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_nxt;
    logic             underrun_nxt;
    logic             underrun_set;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             last_end;
    logic             xfer;

    mod_period_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_IDLE),
        .en   (state == S_RUN),
        .count(count),
        .tc   (tc)
    );

    // tc can only be high in RUN, so it marks the period end directly.
    assign last_end    = (state == S_RUN) && tc && (rep_cnt == '0);
    assign sym_ready   = rst && start && ((state == S_IDLE) || last_end);
    assign xfer        = sym_valid && sym_ready;
    assign busy        = (state == S_RUN);
    assign period_tick = tc;
    assign pwm_out     = busy && (count < duty_reg);

    always_comb begin
        state_nxt    = state;
        duty_nxt     = duty_reg;
        rep_nxt      = rep_cnt;
        underrun_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    state_nxt = S_RUN;
                    duty_nxt  = sym_data;
                    rep_nxt   = sym_rep;
                end
            end
            S_RUN: begin
                if (tc) begin
                    if (rep_cnt != '0) begin
                        rep_nxt = rep_cnt - REP_W'(1);
                    end else if (xfer) begin
                        duty_nxt = sym_data;
                        rep_nxt  = sym_rep;
                    end else begin
                        state_nxt    = S_IDLE;
                        underrun_set = start;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        underrun_nxt = underrun_set || (underrun && start);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            duty_reg <= '0;
            rep_cnt  <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            duty_reg <= duty_nxt;
            rep_cnt  <= rep_nxt;
            underrun <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_symbol_scheduler.sv
// Directed scenarios plus random symbol streams against a symbol-timeline reference model.
module tb_pwm_symbol_scheduler;

    localparam int WIDTH = 4;
    localparam int REP_W = 4;
    localparam int P     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sym_valid;
    logic [WIDTH-1:0] sym_data;
    logic [REP_W-1:0] sym_rep;
    logic             sym_ready;
    logic             pwm_out;
    logic             period_tick;
    logic             busy;
    logic             underrun;

    int n_total = 0;
    int n_bad   = 0;

    // Model: a symbol is a timeline of (rep+1)*P cycles; position is elapsed cycles into it.
    int m_busy = 0;
    int m_el   = 0;
    int m_tot  = 0;
    int m_duty = 0;
    int m_unr  = 0;

    pwm_symbol_scheduler #(
        .WIDTH(WIDTH),
        .REP_W(REP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_rep    (sym_rep),
        .sym_ready  (sym_ready),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input int d, input int r);
        int  pos;
        int  last;
        int  e_rdy;
        int  xf;
        @(negedge clk);
        start     = s;
        sym_valid = v;
        sym_data  = WIDTH'(d);
        sym_rep   = REP_W'(r);
        #1;
        pos   = m_el % P;
        last  = m_busy && (m_el == m_tot - 1);
        e_rdy = s && (!m_busy || last);
        chk("pwm_out",     int'(pwm_out),     m_busy && (pos < m_duty));
        chk("period_tick", int'(period_tick), m_busy && (pos == P - 1));
        chk("sym_ready",   int'(sym_ready),   e_rdy);
        chk("busy",        int'(busy),        m_busy);
        chk("underrun",    int'(underrun),    m_unr);
        xf = v && e_rdy;
        if (!s) m_unr = 0;
        if (!m_busy) begin
            if (xf) begin
                m_busy = 1; m_el = 0; m_tot = (r + 1) * P; m_duty = d;
            end
        end else if (last) begin
            if (xf) begin
                m_el = 0; m_tot = (r + 1) * P; m_duty = d;
            end else begin
                m_busy = 0;
                if (s) m_unr = 1;
            end
        end else begin
            m_el++;
        end
    endtask

    task automatic idle_run(input int n, input logic s);
        for (int i = 0; i < n; i++) step(s, 1'b0, 0, 0);
    endtask

    task automatic reset_check();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_pwm_out",     int'(pwm_out),     0);
        chk("rst_period_tick", int'(period_tick), 0);
        chk("rst_sym_ready",   int'(sym_ready),   0);
        chk("rst_busy",        int'(busy),        0);
        chk("rst_underrun",    int'(underrun),    0);
        m_busy = 0; m_el = 0; m_unr = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_sym_ready", int'(sym_ready), int'(start));
        chk("rel_busy",      int'(busy),      0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b1;
        sym_valid = 1'b0;
        sym_data  = '0;
        sym_rep   = '0;
        #2;
        chk("por_sym_ready", int'(sym_ready), 0);
        chk("por_busy",      int'(busy),      0);
        chk("por_pwm_out",   int'(pwm_out),   0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("por_rel_ready", int'(sym_ready), 1);

        // Single symbol then underrun, then underrun clear and restart.
        step(1'b1, 1'b1, 5, 0);
        idle_run(18, 1'b1);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 5, 0);
        idle_run(17, 1'b0);

        // Back-to-back: 3/16 twice, then 12/16 offered from the start.
        step(1'b1, 1'b1, 3, 1);
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 12, 0);
        idle_run(18, 1'b1);
        step(1'b0, 1'b0, 0, 0);

        // Duty edges.
        step(1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 15, 0);
        idle_run(17, 1'b0);

        // Graceful stop with a symbol still offered.
        step(1'b1, 1'b1, 8, 2);
        idle_run(3, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 7, 0);

        // Reset in the middle of a running period.
        step(1'b1, 1'b1, 5, 0);
        idle_run(2, 1'b1);
        reset_check();

        // Random streams.
        for (int i = 0; i < 2500; i++) begin
            int sel;
            int d;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      d = 0;
            else if (sel == 1) d = P - 1;
            else               d = int'($urandom_range(0, P - 1));
            step($urandom_range(0, 99) < 93, $urandom_range(0, 99) < 70,
                 d, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
